// File: rtl/exmem_mem_access.sv
// EX/MEM pipeline register merged with a req/ack data-memory access controller.
// Define DMEM_TIMEOUT_EN to enable the dmem_ack wait timeout and the sticky mem_err flag.
module exmem_mem_access #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  mux5_out_in,
    input  logic [31:0] adder1_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic        flush_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] data_from_memory_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  mux5_out_out,
    output logic [31:0] adder1_out,
    output logic [1:0]  mem_to_reg_out,
    output logic        reg_write_out,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [31:0] r_alu;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic [31:0] r_pc4;
    logic        r_mem_read;
    logic        r_mem_write;
    logic [1:0]  r_mem_to_reg;
    logic        r_reg_write;
    logic [31:0] r_rdata;

    logic        w_in_req;
    logic        w_timeout;

    assign w_in_req = (r_state == S_REQ);

`ifdef DMEM_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] r_wait;
    logic          r_mem_err;

    // Ack in the same cycle as the limit takes precedence over the timeout.
    assign w_timeout = w_in_req && !dmem_ack && (r_wait == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait    <= '0;
            r_mem_err <= 1'b0;
        end else begin
            if (!w_in_req || w_timeout) begin
                r_wait <= '0;
            end else if (!dmem_ack) begin
                r_wait <= r_wait + 1'b1;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign mem_err = r_mem_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_timeout        = 1'b0;
    assign mem_err          = 1'b0;
`endif

    // The slot only reloads while not waiting on memory; a timed-out op loses its write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_alu        <= '0;
            r_wdata      <= '0;
            r_rd         <= '0;
            r_pc4        <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 2'b00;
            r_reg_write  <= 1'b0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (dmem_ack) begin
                        if (r_mem_read && !r_mem_write) begin
                            r_rdata <= dmem_rdata;
                        end
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_reg_write <= 1'b0;
                        r_state     <= S_RESP;
                    end
                end
                default: begin
                    if (flush_in) begin
                        r_alu        <= '0;
                        r_wdata      <= '0;
                        r_rd         <= '0;
                        r_pc4        <= '0;
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_mem_to_reg <= 2'b00;
                        r_reg_write  <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_alu        <= alu_result_in;
                        r_wdata      <= write_data_in;
                        r_rd         <= mux5_out_in;
                        r_pc4        <= adder1_in;
                        r_mem_read   <= mem_read_in;
                        r_mem_write  <= mem_write_in;
                        r_mem_to_reg <= mem_to_reg_in;
                        r_reg_write  <= reg_write_in;
                        r_state      <= (mem_read_in || mem_write_in) ? S_REQ : S_IDLE;
                    end
                end
            endcase
        end
    end

    assign stall_out            = w_in_req;
    assign dmem_req             = w_in_req;
    assign dmem_we              = w_in_req && r_mem_write;
    assign dmem_addr            = r_alu;
    assign dmem_wdata           = r_wdata;
    assign data_from_memory_out = r_rdata;
    assign alu_result_out       = r_alu;
    assign mux5_out_out         = r_rd;
    assign adder1_out           = r_pc4;
    assign mem_to_reg_out       = r_mem_to_reg;
    assign reg_write_out        = r_reg_write && !w_in_req;

endmodule

// File: tb/tb_exmem_mem_access.sv
// Self-checking bench for exmem_mem_access: table-driven ALU ops plus scoreboarded memory sequences.
module tb_exmem_mem_access;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] aluIn;
    logic [31:0] wdataIn;
    logic [4:0]  rdIn;
    logic [31:0] pc4In;
    logic        memReadIn;
    logic        memWriteIn;
    logic [1:0]  m2rIn;
    logic        regWriteIn;
    logic        flushIn;
    logic        stallOut;
    logic        dmemReq;
    logic        dmemWe;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [31:0] dmemRdata;
    logic        dmemAck;
    logic [31:0] memDataOut;
    logic [31:0] aluOut;
    logic [4:0]  rdOut;
    logic [31:0] pc4Out;
    logic [1:0]  m2rOut;
    logic        regWriteOut;
    logic        memErr;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [1:0]  m2r;
        logic        rw;
        logic        flush;
    } vec_t;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [1:0]  m2r;
        logic        rw;
        logic        chkData;
        logic        chkMem;
        logic [31:0] memData;
    } exp_t;

    exp_t sbQ[$];

    exmem_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .alu_result_in(aluIn), .write_data_in(wdataIn), .mux5_out_in(rdIn),
        .adder1_in(pc4In), .mem_read_in(memReadIn), .mem_write_in(memWriteIn),
        .mem_to_reg_in(m2rIn), .reg_write_in(regWriteIn), .flush_in(flushIn),
        .stall_out(stallOut), .dmem_req(dmemReq), .dmem_we(dmemWe),
        .dmem_addr(dmemAddr), .dmem_wdata(dmemWdata), .dmem_rdata(dmemRdata),
        .dmem_ack(dmemAck), .data_from_memory_out(memDataOut),
        .alu_result_out(aluOut), .mux5_out_out(rdOut), .adder1_out(pc4Out),
        .mem_to_reg_out(m2rOut), .reg_write_out(regWriteOut), .mem_err(memErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                                 input logic [31:0] pc4, input logic mrd, input logic mwr,
                                 input logic [1:0] m2r, input logic rw, input logic fl);
        aluIn = alu; wdataIn = wd; rdIn = rd; pc4In = pc4;
        memReadIn = mrd; memWriteIn = mwr; m2rIn = m2r; regWriteIn = rw; flushIn = fl;
    endtask

    task automatic applyNop();
        applyStimulus(32'h0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic popCompare(input string tag);
        exp_t e;
        checkCount++;
        if (sbQ.size() == 0) begin
            errorCount++;
            $display("[TB] FAIL %s_sb: got empty queue expected entry", tag);
        end else begin
            checkCount--;
            e = sbQ.pop_front();
            checkOutput({tag, "_rw"}, {31'd0, regWriteOut}, {31'd0, e.rw});
            checkOutput({tag, "_m2r"}, {30'd0, m2rOut}, {30'd0, e.m2r});
            if (e.chkData) begin
                checkOutput({tag, "_alu"}, aluOut, e.alu);
                checkOutput({tag, "_rd"}, {27'd0, rdOut}, {27'd0, e.rd});
                checkOutput({tag, "_pc4"}, pc4Out, e.pc4);
            end
            if (e.chkMem) checkOutput({tag, "_mdata"}, memDataOut, e.memData);
        end
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{alu: 32'h10,       rd: 5'd5,  pc4: 32'h1004, m2r: 2'b00, rw: 1'b1, flush: 1'b0};
        vecs[1] = '{alu: 32'hFFFFFFFF, rd: 5'd31, pc4: 32'h2008, m2r: 2'b10, rw: 1'b1, flush: 1'b0};
        vecs[2] = '{alu: 32'h33,       rd: 5'd3,  pc4: 32'h300C, m2r: 2'b10, rw: 1'b1, flush: 1'b1};
        vecs[3] = '{alu: 32'h77,       rd: 5'd9,  pc4: 32'h4010, m2r: 2'b00, rw: 1'b0, flush: 1'b0};

        rst = 1'b0;
        dmemAck = 1'b0;
        dmemRdata = 32'h0;
        applyNop();
        #12;
        checkOutput("rst_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("rst_stall", {31'd0, stallOut}, 32'd0);
        checkOutput("rst_rw", {31'd0, regWriteOut}, 32'd0);
        checkOutput("rst_alu", aluOut, 32'd0);
        checkOutput("rst_m2r", {30'd0, m2rOut}, 32'd0);
        checkOutput("rst_err", {31'd0, memErr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Non-memory ops: one cycle latency, never stalls.
        foreach (vecs[i]) begin
            exp_t e;
            applyStimulus(vecs[i].alu, 32'h0, vecs[i].rd, vecs[i].pc4, 1'b0, 1'b0,
                          vecs[i].m2r, vecs[i].rw, vecs[i].flush);
            e.alu = vecs[i].alu; e.rd = vecs[i].rd; e.pc4 = vecs[i].pc4;
            e.m2r = vecs[i].flush ? 2'b00 : vecs[i].m2r;
            e.rw = vecs[i].flush ? 1'b0 : vecs[i].rw;
            e.chkData = !vecs[i].flush; e.chkMem = 1'b0; e.memData = 32'h0;
            sbQ.push_back(e);
            step();
            popCompare($sformatf("vec%0d", i));
            checkOutput($sformatf("vec%0d_stall", i), {31'd0, stallOut}, 32'd0);
        end

        // Load at 0x40, ack in the third REQ cycle, flush pulsed mid-access.
        applyStimulus(32'h40, 32'h0, 5'd7, 32'h44, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        sbQ.push_back('{alu: 32'h40, rd: 5'd7, pc4: 32'h44, m2r: 2'b01, rw: 1'b1,
                        chkData: 1'b1, chkMem: 1'b1, memData: 32'hDEADBEEF});
        step();
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("ld_req%0d", c), {31'd0, dmemReq}, 32'd1);
            checkOutput($sformatf("ld_addr%0d", c), dmemAddr, 32'h40);
            checkOutput($sformatf("ld_stall%0d", c), {31'd0, stallOut}, 32'd1);
            checkOutput($sformatf("ld_rw%0d", c), {31'd0, regWriteOut}, 32'd0);
            checkOutput($sformatf("ld_we%0d", c), {31'd0, dmemWe}, 32'd0);
            applyNop();
            flushIn = (c == 1);
            if (c == 2) begin
                dmemAck = 1'b1;
                dmemRdata = 32'hDEADBEEF;
            end
            step();
        end
        dmemAck = 1'b0;
        dmemRdata = 32'h0;
        popCompare("ld");
        checkOutput("ld_resp_stall", {31'd0, stallOut}, 32'd0);
        checkOutput("ld_resp_req", {31'd0, dmemReq}, 32'd0);

        // Store with ack in the first REQ cycle, then a both-bits op back-to-back.
        applyStimulus(32'h80, 32'h1234, 5'd2, 32'h84, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        sbQ.push_back('{alu: 32'h80, rd: 5'd2, pc4: 32'h84, m2r: 2'b00, rw: 1'b0,
                        chkData: 1'b1, chkMem: 1'b1, memData: 32'hDEADBEEF});
        step();
        checkOutput("st_req", {31'd0, dmemReq}, 32'd1);
        checkOutput("st_we", {31'd0, dmemWe}, 32'd1);
        checkOutput("st_wdata", dmemWdata, 32'h1234);
        checkOutput("st_addr", dmemAddr, 32'h80);
        checkOutput("st_rw", {31'd0, regWriteOut}, 32'd0);
        dmemAck = 1'b1;
        step();
        dmemAck = 1'b0;
        popCompare("st");
        checkOutput("st_stall_once", {31'd0, stallOut}, 32'd0);
        applyStimulus(32'h84, 32'h55, 5'd4, 32'h88, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
        sbQ.push_back('{alu: 32'h84, rd: 5'd4, pc4: 32'h88, m2r: 2'b00, rw: 1'b0,
                        chkData: 1'b1, chkMem: 1'b1, memData: 32'hDEADBEEF});
        step();
        applyNop();
        checkOutput("b2b_we", {31'd0, dmemWe}, 32'd1);
        checkOutput("b2b_addr", dmemAddr, 32'h84);
        dmemAck = 1'b1;
        dmemRdata = 32'h99999999;
        step();
        dmemAck = 1'b0;
        popCompare("b2b");
        step();

        // A flushed load never reaches memory.
        applyStimulus(32'h60, 32'h0, 5'd8, 32'h64, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
        step();
        applyNop();
        checkOutput("fl_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("fl_rw", {31'd0, regWriteOut}, 32'd0);
        checkOutput("fl_stall", {31'd0, stallOut}, 32'd0);

        // Asynchronous reset during REQ, then a late ack must be ignored.
        applyStimulus(32'h100, 32'h0, 5'd6, 32'h104, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        step();
        checkOutput("ar_req_before", {31'd0, dmemReq}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("ar_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("ar_stall", {31'd0, stallOut}, 32'd0);
        checkOutput("ar_alu", aluOut, 32'd0);
        checkOutput("ar_mdata", memDataOut, 32'd0);
        applyNop();
        dmemAck = 1'b1;
        dmemRdata = 32'hCAFEF00D;
        @(negedge clk);
        rst = 1'b1;
        step();
        checkOutput("late_ack_req", {31'd0, dmemReq}, 32'd0);
        checkOutput("late_ack_rw", {31'd0, regWriteOut}, 32'd0);
        checkOutput("late_ack_mdata", memDataOut, 32'd0);
        dmemAck = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        // No ack: request holds four cycles, then the op is discarded with mem_err set.
        applyStimulus(32'h200, 32'h0, 5'd10, 32'h204, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        step();
        applyNop();
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("to_req%0d", c), {31'd0, dmemReq}, 32'd1);
            step();
        end
        checkOutput("to_req_drop", {31'd0, dmemReq}, 32'd0);
        checkOutput("to_err", {31'd0, memErr}, 32'd1);
        checkOutput("to_rw", {31'd0, regWriteOut}, 32'd0);
        checkOutput("to_stall", {31'd0, stallOut}, 32'd0);
        step();
        step();
        checkOutput("to_err_sticky", {31'd0, memErr}, 32'd1);
`else
        checkOutput("no_to_err", {31'd0, memErr}, 32'd0);
`endif

        if (sbQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL sb_leftover: got %0d entries expected 0", sbQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
